// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared funct3 codes, FSM encoding and M-extension funct7 for ex_muldiv
// Contents: F3_* op selects, S_* state codes, F7_MULDIV
package ex_muldiv_pkg;
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUSY    = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;
endpackage

// File: rtl/ex_muldiv_signfix.sv
// ex_muldiv_signfix: conditional two's-complement negate (abs of operands, sign fix of results)
// Ports: val_i value in, neg_i negate when high, val_o value out (mod 2^W)
module ex_muldiv_signfix
   import ex_muldiv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] val_o
);
   assign val_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in EX, stalls the pipe while computing
// Ports: clk_i/rst_i clock and sync active-high reset; valid_i, funct3_i, rs1_data_i,
//   rs2_data_i, rd_addr_i from ID_EX; flush_i squash; stall_o holds PC/IF_ID/ID_EX;
//   done_o one-cycle result strobe with result_o and rd_addr_o.
// Build option: EX_MULDIV_FAST_MUL_EN selects a single-cycle registered multiplier.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o
);
   localparam int CW = $clog2(XLEN);
   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   b_q, b_d, res_q, res_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
   logic [XLEN-1:0]   a_mag, b_mag, fin;
   logic [XLEN:0]     add, rem_sh, trial;
   logic [2*XLEN-1:0] step, pre, fixd;
   assign a_sgn = funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
   assign b_sgn = funct3_i inside {F3_MULH, F3_DIV, F3_REM};
   assign a_neg = a_sgn & rs1_data_i[XLEN-1];
   assign b_neg = b_sgn & rs2_data_i[XLEN-1];
   assign div0  = funct3_i[2] & (rs2_data_i == '0);
   assign ovf   = funct3_i[2] & ~funct3_i[0] & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data_i);
   ex_muldiv_signfix #(.W(XLEN)) u_abs_a (.val_i(rs1_data_i), .neg_i(a_neg), .val_o(a_mag));
   ex_muldiv_signfix #(.W(XLEN)) u_abs_b (.val_i(rs2_data_i), .neg_i(b_neg), .val_o(b_mag));
   // acc = {hi, lo}: multiply shifts the product right through lo (multiplier);
   // divide shifts left, hi is the partial remainder and lo collects quotient bits.
   assign add    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign rem_sh = acc_q[2*XLEN-1:XLEN-1];
   assign trial  = rem_sh - {1'b0, b_q};
   assign step   = ~f3_q[2] ? {add, acc_q[XLEN-1:1]} :
                   trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                                 {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   // Quotient/remainder are zero-extended so one 2*XLEN negator serves every op.
   assign pre = f3_q[2] ? {{XLEN{1'b0}}, f3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0]} : step;
   ex_muldiv_signfix #(.W(2*XLEN)) u_fix (.val_i(pre), .neg_i(neg_q), .val_o(fixd));
   assign fin = (~f3_q[2] & (f3_q[1:0] != 2'b00)) ? fixd[2*XLEN-1:XLEN] : fixd[XLEN-1:0];
`ifdef EX_MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     fa, fb;
   logic signed [2*XLEN+1:0] fp;
   logic [XLEN-1:0]          fast_res;
   assign fa       = {a_sgn & rs1_data_i[XLEN-1], rs1_data_i};
   assign fb       = {b_sgn & rs2_data_i[XLEN-1], rs2_data_i};
   assign fp       = fa * fb;
   assign fast_res = (funct3_i == F3_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      neg_d   = neg_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      if (flush_i) state_d = S_IDLE;
      else if (state_q == S_IDLE) begin
         if (valid_i) begin
            f3_d  = funct3_i;
            rd_d  = rd_addr_i;
            neg_d = (funct3_i == F3_REM) ? a_neg : a_neg ^ b_neg;
            b_d   = b_mag;
            acc_d = {{XLEN{1'b0}}, a_mag};
            cnt_d = CW'(XLEN - 1);
            if (div0 | ovf) begin
               state_d = S_DONE;
               res_d   = div0 ? (funct3_i[1] ? rs1_data_i : '1) : (funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
            end
`ifdef EX_MULDIV_FAST_MUL_EN
            else if (~funct3_i[2]) begin
               state_d = S_DONE;
               res_d   = fast_res;
            end
`endif
            else state_d = S_BUSY;
         end
      end else if (state_q == S_BUSY) begin
         acc_d = step;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) begin
            state_d = S_DONE;
            res_d   = fin;
         end
      end else state_d = S_IDLE;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         neg_q   <= 1'b0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         neg_q   <= neg_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end
   assign stall_o   = (state_q == S_BUSY) | ((state_q == S_IDLE) & valid_i & ~flush_i);
   assign done_o    = state_q == S_DONE;
   assign result_o  = res_q;
   assign rd_addr_o = rd_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector bench for ex_muldiv
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;
`ifdef EX_MULDIV_FAST_MUL_EN
   localparam int ML = 2, MS = 1;
`else
   localparam int ML = 34, MS = 33;
`endif
   logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, flush = 1'b0;
   logic [2:0]  f3 = '0;
   logic [31:0] a = '0, b = '0;
   logic [4:0]  rd = '0;
   logic        stall, done;
   logic [31:0] result;
   logic [4:0]  rd_o;
   int          total = 0, bad = 0;
   ex_muldiv dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .funct3_i(f3), .rs1_data_i(a),
      .rs2_data_i(b), .rd_addr_i(rd), .flush_i(flush), .stall_o(stall),
      .done_o(done), .result_o(result), .rd_addr_o(rd_o)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a, b, exp;
      int          lat, st;
   } vec_t;
   vec_t v[20];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask
   task automatic run_op(input logic [2:0] of3, input logic [31:0] oa, input logic [31:0] ob,
                         input logic [4:0] ord, output int lat, output int st,
                         output logic [31:0] res, output logic [4:0] rdo);
      @(negedge clk);
      f3 = of3; a = oa; b = ob; rd = ord; valid = 1'b1;
      #1;
      lat = 0; st = 0; res = 'x; rdo = 'x;
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) @(negedge clk);
         if (stall) st++;
         if (done) begin
            lat = k; res = result; rdo = rd_o;
            break;
         end
      end
      valid = 1'b0;
      @(negedge clk);
      chk("no_dup_done", {31'b0, done}, 32'd0);
   endtask
   initial begin
      int lat, st, n, first, second;
      logic [31:0] res;
      logic [4:0] rdo;
      v[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, ML, MS};
      v[1]  = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, ML, MS};
      v[2]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML, MS};
      v[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML, MS};
      v[4]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14,       34, 33};
      v[5]  = '{F3_REMU,   32'd100,      32'd7,        32'd2,        34, 33};
      v[6]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 33};
      v[7]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 33};
      v[8]  = '{F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2,  1};
      v[9]  = '{F3_REM,    32'd5,        32'd0,        32'd5,        2,  1};
      v[10] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  1};
      v[11] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  1};
      v[12] = '{F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2,  1};
      v[13] = '{F3_REMU,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2,  1};
      v[14] = '{F3_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 2,  1};
      v[15] = '{F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 33};
      v[16] = '{F3_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 33};
      v[17] = '{F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 33};
      v[18] = '{F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34, 33};
      v[19] = '{F3_MULH,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, ML, MS};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd", {27'b0, rd_o}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         run_op(v[i].f3, v[i].a, v[i].b, 5'(i + 1), lat, st, res, rdo);
         chk($sformatf("v%0d_result", i), res, v[i].exp);
         chk($sformatf("v%0d_latency", i), lat, v[i].lat);
         chk($sformatf("v%0d_stall_cycles", i), st, v[i].st);
         chk($sformatf("v%0d_rd", i), {27'b0, rdo}, 32'(i + 1));
      end
      @(negedge clk);
      f3 = F3_DIVU; a = 32'd100; b = 32'd7; rd = 5'd20; valid = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("flush_pre_stall", {31'b0, stall}, 32'd1);
      flush = 1'b1; valid = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_done", {31'b0, done}, 32'd0);
      chk("flush_stall", {31'b0, stall}, 32'd0);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("flush_no_done", n, 0);
      run_op(F3_DIVU, 32'd9, 32'd3, 5'd21, lat, st, res, rdo);
      chk("post_flush_result", res, 32'd3);
      chk("post_flush_latency", lat, 34);
      chk("post_flush_rd", {27'b0, rdo}, 32'd21);
      @(negedge clk);
      f3 = F3_MUL; a = 32'd7; b = 32'hFFFFFFFD; rd = 5'd9; valid = 1'b1;
      #1;
      n = 0; first = 0; second = 0;
      for (int k = 1; k <= 70; k++) begin
         if (k > 1) @(negedge clk);
         if (done) begin
            n++;
            if (n == 1) first = k;
            if (n == 2) second = k;
            chk("b2b_result", result, 32'hFFFFFFEB);
         end
      end
      chk("b2b_pulses", n, 70 / ML);
      chk("b2b_first", first, ML);
      chk("b2b_gap", second - first, ML);
      valid = 1'b0;
`ifndef EX_MULDIV_FAST_MUL_EN
      chk("b2b_busy_again", {31'b0, stall}, 32'd1);
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_stall", {31'b0, stall}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_rd", {27'b0, rd_o}, 32'd0);
      run_op(F3_REMU, 32'd100, 32'd7, 5'd3, lat, st, res, rdo);
      chk("post_rst_result", res, 32'd2);
      chk("post_rst_latency", lat, 34);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
